// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered Hack-style ALU with flags and multi-cycle shift-add multiply
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             consume;
  logic             mul_done;

  logic [WIDTH-1:0] xa, xb, ya, yb, r, h_out;
  logic [WIDTH:0]   sum;
  logic             h_cy, h_ov;

  assign accept   = in_valid & in_ready;
  assign consume  = out_valid & out_ready;
  assign mul_done = (state == MUL) && (cnt == CNT_W'(WIDTH - 1));
  assign acc_nxt  = mplier[0] ? (acc + mcand) : acc;

  // Hack ALU datapath; carry and overflow are taken before the 'no' inversion
  always_comb begin
    xa    = ctrl[5] ? '0 : x;
    xb    = ctrl[4] ? ~xa : xa;
    ya    = ctrl[3] ? '0 : y;
    yb    = ctrl[2] ? ~ya : ya;
    sum   = {1'b0, xb} + {1'b0, yb};
    r     = ctrl[1] ? sum[WIDTH-1:0] : (xb & yb);
    h_out = ctrl[0] ? ~r : r;
    h_cy  = ctrl[1] & sum[WIDTH];
    h_ov  = ctrl[1] & (xb[WIDTH-1] == yb[WIDTH-1]) & (sum[WIDTH-1] != xb[WIDTH-1]);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: enter MUL on a multiply accept, leave after the last iteration
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && mul) state_nxt = MUL;
      MUL:     if (mul_done)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs: only accept when idle and the result slot is free or draining
  always_comb begin
    busy     = (state == MUL);
    in_ready = (state == IDLE) & (~out_valid | out_ready);
  end

  // Multiply iteration registers: latch on accept, shift-add each MUL cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept && mul) begin
      mcand  <= x;
      mplier <= y;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Result registers: Hack result on accept, product on the final iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      zr        <= 1'b1;
      ng        <= 1'b0;
      cy        <= 1'b0;
      ov        <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept && !mul) begin
      out       <= h_out;
      zr        <= (h_out == '0);
      ng        <= h_out[WIDTH-1];
      cy        <= h_cy;
      ov        <= h_ov;
      out_valid <= 1'b1;
    end else if (mul_done) begin
      out       <= acc_nxt;
      zr        <= (acc_nxt == '0);
      ng        <= acc_nxt[WIDTH-1];
      cy        <= 1'b0;
      ov        <= 1'b0;
      out_valid <= 1'b1;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe with directed and random stimulus
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [5:0]  ctrl;
  logic        mul;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr, ng, cy, ov, busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] out;
    logic        cy;
    logic        ov;
  } res_t;

  res_t q[$];

  logic [5:0]  enc[18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                           6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                           6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};
  logic [15:0] lit[18] = '{16'd0, 16'd1, 16'hFFFF, 16'd100, 16'd3, 16'hFF9B,
                           16'hFFFC, 16'hFF9C, 16'hFFFD, 16'd101, 16'd4, 16'd99,
                           16'd2, 16'd103, 16'd97, 16'hFF9F, 16'd0, 16'd103};

  alu_pipe #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl), .mul(mul),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zr(zr), .ng(ng), .cy(cy), .ov(ov), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [5:0] c, input logic m);
    res_t        res;
    logic [15:0] xp, yp, rr;
    logic [31:0] prod;
    int          us, ss;
    res.cy = 1'b0;
    res.ov = 1'b0;
    if (m) begin
      prod    = {16'b0, a} * {16'b0, b};
      res.out = prod[15:0];
    end else begin
      xp = c[5] ? 16'h0 : a;
      if (c[4]) xp = ~xp;
      yp = c[3] ? 16'h0 : b;
      if (c[2]) yp = ~yp;
      if (c[1]) begin
        us     = int'({16'b0, xp}) + int'({16'b0, yp});
        ss     = int'($signed(xp)) + int'($signed(yp));
        rr     = us[15:0];
        res.cy = (us > 65535);
        res.ov = (ss > 32767) || (ss < -32768);
      end else begin
        rr = xp & yp;
      end
      res.out = c[0] ? ~rr : rr;
    end
    return res;
  endfunction

  initial begin
    res_t e;
    int   n;
    int   stale;
    int   nacc;
    int   nres;

    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; ctrl = '0; mul = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_out", {16'b0, out}, 32'h0);
    chk("rst_flags", {27'b0, zr, ng, cy, ov, out_valid}, {27'b0, 5'b10000});
    chk("rst_busy_rdy", {30'b0, busy, in_ready}, 32'b01);
    rst = 1'b0;

    // all 18 Hack encodings back to back, one result per cycle
    x = 16'd100; y = 16'd3; in_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      ctrl = enc[i];
      chk("hack_rdy", {31'b0, in_ready}, 32'd1);
      step();
      e = model(16'd100, 16'd3, enc[i], 1'b0);
      chk("hack_model", {14'b0, out, cy, ov}, {14'b0, e.out, e.cy, e.ov});
      chk("hack_lit", {15'b0, out_valid, out}, {15'b0, 1'b1, lit[i]});
      chk("hack_flags", {30'b0, zr, ng}, {30'b0, lit[i] == 16'h0, lit[i][15]});
    end

    // overflow and carry boundaries
    x = 16'h7FFF; y = 16'h0001; ctrl = 6'b000010;
    step();
    chk("ovf", {12'b0, out, zr, ng, cy, ov}, {12'b0, 16'h8000, 4'b0101});
    x = 16'hFFFF; y = 16'h0001;
    step();
    chk("carry", {12'b0, out, zr, ng, cy, ov}, {12'b0, 16'h0000, 4'b1010});
    in_valid = 1'b0;

    // multiply latency and busy window
    step();
    in_valid = 1'b1; mul = 1'b1; x = 16'd100; y = 16'd3;
    step();
    in_valid = 1'b0; mul = 1'b0; x = 16'hDEAD; y = 16'hBEEF;
    chk("mul_start", {29'b0, busy, in_ready, out_valid}, 32'b100);
    for (int k = 1; k < 16; k++) begin
      step();
      chk("mul_wait", {29'b0, busy, in_ready, out_valid}, 32'b100);
    end
    step();
    chk("mul_done", {13'b0, busy, out_valid, zr, out}, {13'b0, 3'b010, 16'd300});

    in_valid = 1'b1; mul = 1'b1; x = 16'hFFFF; y = 16'hFFFF;
    step();
    in_valid = 1'b0; mul = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk("mul_lat", n, 32'd16);
    chk("mul_ffff", {12'b0, out, zr, ng, cy, ov}, {12'b0, 16'h0001, 4'b0000});

    // backpressure holds result and blocks the next op
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; x = 16'd100; y = 16'd3; ctrl = 6'b000010;
    step();
    chk("bp_first", {15'b0, out_valid, out}, {15'b0, 1'b1, 16'd103});
    ctrl = 6'b000000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold", {14'b0, in_ready, out_valid, out}, {14'b0, 2'b01, 16'd103});
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_next", {14'b0, out_valid, zr, out}, {14'b0, 2'b11, 16'd0});

    // reset mid-multiply discards the operation
    step();
    in_valid = 1'b1; mul = 1'b1; x = 16'd100; y = 16'd3;
    step();
    in_valid = 1'b0; mul = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("mrst_out", {12'b0, out, zr, ng, cy, ov}, {12'b0, 16'h0, 4'b1000});
    chk("mrst_hs", {29'b0, busy, in_ready, out_valid}, 32'b010);
    rst = 1'b0;
    stale = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (out_valid) stale++;
    end
    chk("mrst_stale", stale, 32'd0);

    // random ops with random stalls against the model
    nacc = 0;
    nres = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      mul       = ($urandom_range(0, 4) == 0);
      x         = 16'($urandom);
      y         = 16'($urandom);
      ctrl      = 6'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_extra", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rnd", {12'b0, out, zr, ng, cy, ov},
              {12'b0, e.out, e.out == 16'h0, e.out[15], e.cy, e.ov});
          nres++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(x, y, ctrl, mul));
        nacc++;
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (out_valid && q.size() != 0) begin
        e = q.pop_front();
        chk("rnd_drain", {12'b0, out, zr, ng, cy, ov},
            {12'b0, e.out, e.out == 16'h0, e.out[15], e.cy, e.ov});
        nres++;
      end
      step();
    end
    chk("rnd_count", nres, nacc);
    chk("rnd_left", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
